// File: rtl/play_buf_pkg.sv
// play_buf shared types: playback state encoding and address helpers.
package play_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_RUN
    } state_t;

    localparam int AW_DEF = 6;
    localparam int DW_DEF = 16;

    function automatic int last_addr(input int aw);
        return (1 << aw) - 1;
    endfunction

    localparam int LAST_ADDR = last_addr(AW_DEF);

endpackage

// File: rtl/play_buf_dpram.sv
// Simple dual-port RAM: port a writes, port b has a registered read.
module dpram #(
    parameter int aw = 7,
    parameter int dw = 16
) (
    input  logic          clka,
    input  logic          wea,
    input  logic [aw-1:0] addra,
    input  logic [dw-1:0] dina,
    input  logic          clkb,
    input  logic          enb,
    input  logic [aw-1:0] addrb,
    output logic [dw-1:0] doutb
);

    logic [dw-1:0] r_mem [0:(1<<aw)-1];

    always_ff @(posedge clka) begin
        if (wea) r_mem[addra] <= dina;
    end

    always_ff @(posedge clkb) begin
        if (enb) doutb <= r_mem[addrb];
    end

endmodule

// File: rtl/play_buf.sv
// Double-buffered block playback buffer; host stages a bank, trig replays it.
// Optional PLAY_BUF_RETRIG_EN: trig during RUN queues a back-to-back replay.
module play_buf
    import play_buf_pkg::*;
#(
    parameter int aw = AW_DEF,
    parameter int dw = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [aw-1:0] host_addr,
    input  logic [dw-1:0] host_data,
    input  logic          host_we,
    input  logic          commit,
    output logic          commit_pending,
    output logic          ready,
    input  logic          stb_in,
    input  logic          boundary,
    input  logic          trig,
    output logic [dw-1:0] d_out,
    output logic          stb_out,
    output logic          active
);

    localparam logic [aw-1:0] W_LAST = aw'(last_addr(aw));

    state_t        r_state;
    state_t        w_next;
    logic          r_pbank;
    logic          r_pend;
    logic          r_ready;
    logic          r_stb_out;
    logic [aw-1:0] r_rd_addr;
    logic          w_run;
    logic          w_last_stb;
    logic          w_swap;
    logic          w_exit_pend;
    logic [dw-1:0] w_doutb;

    assign w_run      = (r_state == ST_RUN);
    assign w_last_stb = w_run && stb_in && (r_rd_addr == W_LAST);

`ifdef PLAY_BUF_RETRIG_EN
    logic r_retrig;

    assign w_exit_pend = r_retrig || trig;
    // A retriggered run takes the new bank, so swap on the exit edge itself.
    assign w_swap = r_pend && (!w_run || (w_last_stb && w_exit_pend));

    always_ff @(posedge clk) begin
        if (rst || w_last_stb) r_retrig <= 1'b0;
        else if (w_run && trig) r_retrig <= 1'b1;
    end
`else
    assign w_exit_pend = 1'b0;
    assign w_swap      = r_pend && !w_run;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (trig && (r_ready || w_swap)) w_next = ST_PEND;
            ST_PEND: if (boundary) w_next = ST_RUN;
            ST_RUN: begin
                if (w_last_stb) w_next = w_exit_pend ? ST_PEND : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pbank   <= 1'b0;
            r_pend    <= 1'b0;
            r_ready   <= 1'b0;
            r_stb_out <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_state   <= w_next;
            r_stb_out <= w_run && stb_in;
            if (w_swap) begin
                r_pbank <= ~r_pbank;
                r_pend  <= 1'b0;
                r_ready <= 1'b1;
            end else if (commit) begin
                r_pend <= 1'b1;
            end
            if (r_state == ST_PEND && boundary) r_rd_addr <= '0;
            else if (w_run && stb_in) r_rd_addr <= r_rd_addr + 1'b1;
        end
    end

    dpram #(
        .aw(aw + 1),
        .dw(dw)
    ) u_ram (
        .clka (clk),
        .wea  (host_we && !r_pend),
        .addra({~r_pbank, host_addr}),
        .dina (host_data),
        .clkb (clk),
        .enb  (w_run && stb_in),
        .addrb({r_pbank, r_rd_addr}),
        .doutb(w_doutb)
    );

    assign d_out          = r_stb_out ? w_doutb : '0;
    assign stb_out        = r_stb_out;
    assign active         = w_run;
    assign commit_pending = r_pend;
    assign ready          = r_ready;

endmodule
